// File: rtl/nios_system_iic_master.sv
// nios_system_iic_master: Avalon-MM slave that shifts a 24-bit frame out as an IIC write (START, 3 bytes + ACKs, STOP)
module nios_system_iic_master #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_out,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;
  state_t state, state_n;
  logic [1:0]  q, q_n;
  logic [4:0]  idx, idx_n;
  logic [23:0] frame, sh;
  logic [15:0] cnt;
  logic        ack_err, nack, sda_m, sda_s, tick, start, ack_slot;
  logic [7:0]  unused_wd;
  assign unused_wd = writedata[31:24];
  assign start     = chipselect && !write_n && address == 2'd0 && state == IDLE;
  assign busy      = state != IDLE;
  assign tick      = busy && cnt == 16'(CLK_DIV - 1);
  assign ack_slot  = idx == 5'd8 || idx == 5'd17 || idx == 5'd26;
  // Zero-wait-state register read mux
  always_comb
    readdata = address == 2'd0 ? {8'b0, frame} : address == 2'd1 ? {30'b0, ack_err, busy} : 32'b0;
  // Two-flop synchroniser for the asynchronous SDA pin
  always_ff @(posedge clk)
    if (reset) {sda_m, sda_s} <= 2'b11;
    else {sda_m, sda_s} <= {sda_in, sda_m};
  // Quarter-bit tick divider, held at zero while idle
  always_ff @(posedge clk)
    if (reset || !busy || tick) cnt <= '0;
    else cnt <= cnt + 16'd1;
  // FSM state register
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      q     <= q_n;
      idx   <= idx_n;
    end
  // Frame capture, bit shifter and ACK sampling
  always_ff @(posedge clk)
    if (reset) begin
      frame   <= '0;
      sh      <= '0;
      ack_err <= 1'b0;
      nack    <= 1'b0;
    end else if (start) begin
      frame   <= writedata[23:0];
      sh      <= writedata[23:0];
      ack_err <= 1'b0;
      nack    <= 1'b0;
    end else if (tick && state == BIT) begin
      if (q == 2'd2 && ack_slot && sda_s) begin
        ack_err <= 1'b1;
        nack    <= 1'b1;
      end
      if (q == 2'd3 && !ack_slot) sh <= sh << 1;
    end
  // Next-state logic: START 2 quarters, 27 bits of 4 quarters, STOP 3 quarters
  always_comb begin
    state_n = state;
    q_n     = q;
    idx_n   = idx;
    case (state)
      IDLE: if (start) begin
        state_n = START;
        q_n     = '0;
      end
      START: if (tick) begin
        state_n = q == 2'd1 ? BIT : START;
        q_n     = q == 2'd1 ? 2'd0 : q + 2'd1;
        idx_n   = '0;
      end
      BIT: if (tick) begin
        q_n = q + 2'd1;
        if (q == 2'd3) begin
          state_n = nack || idx == 5'd26 ? STOP : BIT;
          idx_n   = idx + 5'd1;
        end
      end
      STOP: if (tick) begin
        state_n = q == 2'd2 ? IDLE : STOP;
        q_n     = q == 2'd2 ? 2'd0 : q + 2'd1;
      end
    endcase
  end
  // Pin decode: SDA only moves in low-SCL quarters except at START/STOP
  always_comb begin
    scl_out = state == IDLE || (state == START && q == 2'd0) || (state == BIT && q[1]) || (state == STOP && q != 2'd0);
    sda_oe  = state == START || (state == BIT && !ack_slot && !sh[23]) || (state == STOP && q != 2'd2);
  end
endmodule

// File: tb/tb_nios_system_iic_master.sv
// tb_nios_system_iic_master: scoreboard bench with bus-decoding slave model for three divider settings
module tb_nios_system_iic_master;
  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  address = '0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic        cs[3] = '{1'b0, 1'b0, 1'b0};
  logic        pull[3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] rdata[3];
  logic        scl[3], oe[3], bsy[3], line[3];
  logic [3:0]  ack_en = 4'hF;
  logic [11:0] exp_q[$];
  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic        ps[3], pd[3];
  int          bc[3], bi[3];
  logic [7:0]  sh[3];
  logic [31:0] rv;
  int          t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DIV = g == 0 ? 4 : g == 1 ? 2 : 125;
    assign line[g] = !(oe[g] || pull[g]);
    nios_system_iic_master #(.CLK_DIV(DIV)) u_dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs[g]), .write_n(write_n),
      .writedata(writedata), .readdata(rdata[g]), .scl_out(scl[g]), .sda_oe(oe[g]),
      .sda_in(line[g]), .busy(bsy[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endtask

  task automatic push(input int i, input int k, input logic [7:0] v);
    exp_q.push_back({2'(i), 2'(k), v});
  endtask

  task automatic ev(input int i, input int k, input logic [7:0] v);
    logic [11:0] e, x;
    e = {2'(i), 2'(k), v};
    if (exp_q.size() == 0) chk("unexpected_bus_event", 32'(e), 32'h0);
    else begin
      x = exp_q.pop_front();
      chk("bus_event", 32'(e), 32'(x));
    end
  endtask

  task automatic wr(input int i, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; cs[i] = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1 cs[i] = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input int i, input logic [1:0] a, output logic [31:0] d);
    address = a; cs[i] = 1'b1; write_n = 1'b1;
    #1 d = rdata[i];
    cs[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int ts, input int ex, input string nm);
    int n = 0;
    chk({nm, "_rise"}, 32'(bsy[i]), 32'h1);
    while (bsy[i] && n < 20000) begin
      @(posedge clk);
      #1 n++;
    end
    chk(nm, 32'(cyc - ts), 32'(ex));
  endtask

  // Slave model and bus monitor: decodes START/bytes/STOP, ACKs per ack_en, checks against the scoreboard
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      logic s, d;
      s = scl[i];
      d = line[i];
      if (reset) begin
        bc[i] = 0; bi[i] = 0; pull[i] = 1'b0;
      end else if (ps[i] && s && d != pd[i]) begin
        if (!d) begin
          ev(i, 1, 8'h00);
          bc[i] = 0; bi[i] = 0; pull[i] = 1'b0;
        end else ev(i, 3, 8'h00);
      end else if (!ps[i] && s) begin
        if (bc[i] < 8) begin
          sh[i] = {sh[i][6:0], d};
          bc[i]++;
          if (bc[i] == 8) ev(i, 2, sh[i]);
        end else if (bc[i] == 8) bc[i] = 9;
      end else if (ps[i] && !s) begin
        if (bc[i] == 8) pull[i] = ack_en[bi[i] & 3];
        else if (bc[i] == 9) begin
          pull[i] = 1'b0; bc[i] = 0; bi[i]++;
        end
      end
      ps[i] = s;
      pd[i] = d;
    end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    chk("reset_scl", 32'(scl[0]), 32'h1);
    chk("reset_sda_oe", 32'(oe[0]), 32'h0);
    chk("reset_busy", 32'(bsy[0]), 32'h0);
    rd(0, 2'd1, rv); chk("reset_status", rv, 32'h0);
    rd(0, 2'd0, rv); chk("reset_frame", rv, 32'h0);

    push(0, 1, 0); push(0, 2, 8'h34); push(0, 2, 8'h1E); push(0, 2, 8'h00); push(0, 3, 0);
    wr(0, 2'd0, 32'h00341E00);
    t0 = cyc;
    wait_idle(0, t0, 452, "busy_cycles_full");
    repeat (5) @(negedge clk);
    chk("queue_empty_full", 32'(exp_q.size()), 32'h0);
    rd(0, 2'd1, rv); chk("status_after_full", rv, 32'h0);
    rd(0, 2'd0, rv); chk("frame_after_full", rv, 32'h00341E00);

    wr(0, 2'd1, 32'hFFFFFFFF);
    wr(0, 2'd2, 32'h00123456);
    wr(0, 2'd3, 32'h00ABCDEF);
    repeat (20) @(negedge clk);
    chk("unused_write_busy", 32'(bsy[0]), 32'h0);
    rd(0, 2'd2, rv); chk("read_addr2", rv, 32'h0);
    rd(0, 2'd3, rv); chk("read_addr3", rv, 32'h0);
    rd(0, 2'd0, rv); chk("frame_after_unused", rv, 32'h00341E00);
    rd(0, 2'd1, rv); chk("status_after_unused", rv, 32'h0);

    ack_en = 4'b1110;
    push(0, 1, 0); push(0, 2, 8'h5A); push(0, 3, 0);
    wr(0, 2'd0, 32'h005A1234);
    t0 = cyc;
    wait_idle(0, t0, 164, "busy_cycles_nack");
    repeat (5) @(negedge clk);
    chk("queue_empty_nack", 32'(exp_q.size()), 32'h0);
    rd(0, 2'd1, rv); chk("status_after_nack", rv, 32'h2);

    ack_en = 4'hF;
    push(0, 1, 0); push(0, 2, 8'hA5); push(0, 2, 8'h0F); push(0, 2, 8'h81); push(0, 3, 0);
    wr(0, 2'd0, 32'h00A50F81);
    t0 = cyc;
    rd(0, 2'd1, rv); chk("status_clear_on_start", rv, 32'h1);
    repeat (100) @(posedge clk);
    wr(0, 2'd0, 32'h00AABBCC);
    rd(0, 2'd0, rv); chk("frame_write_while_busy", rv, 32'h00A50F81);
    wait_idle(0, t0, 452, "busy_cycles_wwb");
    repeat (20) @(negedge clk);
    chk("no_restart", 32'(bsy[0]), 32'h0);
    chk("queue_empty_wwb", 32'(exp_q.size()), 32'h0);

    push(0, 1, 0); push(0, 2, 8'hC3);
    wr(0, 2'd0, 32'h00C33CFF);
    repeat (205) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midreset_scl", 32'(scl[0]), 32'h1);
    chk("midreset_sda_oe", 32'(oe[0]), 32'h0);
    chk("midreset_busy", 32'(bsy[0]), 32'h0);
    rd(0, 2'd1, rv); chk("midreset_status", rv, 32'h0);
    rd(0, 2'd0, rv); chk("midreset_frame", rv, 32'h0);
    repeat (40) @(negedge clk);
    chk("queue_empty_midreset", 32'(exp_q.size()), 32'h0);

    push(1, 1, 0); push(1, 2, 8'h34); push(1, 2, 8'h1E); push(1, 2, 8'h00); push(1, 3, 0);
    wr(1, 2'd0, 32'h00341E00);
    t0 = cyc;
    wait_idle(1, t0, 226, "busy_cycles_div2");
    repeat (5) @(negedge clk);
    chk("queue_empty_div2", 32'(exp_q.size()), 32'h0);

    push(2, 1, 0); push(2, 2, 8'h34); push(2, 2, 8'h1E); push(2, 2, 8'h00); push(2, 3, 0);
    wr(2, 2'd0, 32'h00341E00);
    t0 = cyc;
    wait_idle(2, t0, 14125, "busy_cycles_div125");
    repeat (5) @(negedge clk);
    chk("queue_empty_div125", 32'(exp_q.size()), 32'h0);
    rd(2, 2'd1, rv); chk("status_div125", rv, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nios_system_iic_master.md
Name: nios_system_iic_master

Overview:
- Avalon-MM slave that replaces software bit-banging of the IIC clock/data PIOs with a hardware IIC write master.
- Used to configure the audio codec.
- The Nios writes one 24-bit frame (device address byte, register byte, data byte); the block generates START, 27 clocked bits (3 bytes + 3 ACK slots), then STOP on open-drain SCL/SDA.
- Sits between the Avalon interconnect and the codec IIC pins, taking the place of the clock-bit/data-bit PIO pair.

Parameters:
- CLK_DIV, 125, clk cycles per quarter-bit tick (50 MHz / (4×125) = 100 kHz SCL); legal range 2..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, combinational, zero wait states.
- scl_out  out  1  SCL level; 1 = released/high, 0 = driven low.
- sda_oe  out  1  SDA pull-down enable; 1 = drive pin low, 0 = release.
- sda_in  in  1  SDA pin level, asynchronous to clk.
- busy  out  1  transfer in progress; mirrors status bit 0.

Behaviour:
- **Reset values:** scl_out=1, sda_oe=0, busy=0, ack_err=0, frame register=0, FSM=IDLE, tick counter=0. Reset mid-transfer aborts immediately with no STOP generated; pins are released on the cycle after reset is sampled.
- **Register map, address 0 (FRAME):**
  - Write with chipselect && !write_n stores writedata[23:0] as {dev[7:0], reg[7:0], dat[7:0]}.
  - If IDLE, the write starts a transfer, sets busy on the next clk edge and clears ack_err.
  - If busy, the write is ignored entirely: FRAME unchanged, no restart.
  - Read returns {8'b0, FRAME}.
- **Register map, address 1 (STATUS):** read = {30'b0, ack_err, busy}; writes ignored.
- **Register map, addresses 2–3:** read 0; writes ignored.
- **sda_in sync:** 2-flop synchroniser. All sampling uses the synchronised value.
- **Tick generator:** counter runs only while busy. It pulses tick for one clk every CLK_DIV cycles, counting from the start edge, and resets to 0 on entering IDLE.
- **FSM (advances on tick only):**
  - IDLE: scl=1, sda released.
  - START (2 ticks): Q0 scl=1 sda low; Q1 scl=0 sda low.
  - BIT (4 ticks per bit, MSB first, bit index 0..26):
    - Q0: scl=0, sda=data bit (sda_oe = ~bit).
    - Q1: scl=0.
    - Q2: scl=1.
    - Q3: scl=1.
    - SDA changes only while scl=0.
  - ACK slots: bit indices 8, 17 and 26 release SDA. Synchronised sda_in is sampled on the tick ending Q2. If sampled 1 (NACK): set ack_err, finish Q3, go to STOP. No further bytes are sent.
  - STOP (3 ticks): Q0 scl=0 sda low; Q1 scl=1 sda low; Q2 scl=1 sda released. Then IDLE and busy=0.
- **Timing:** a fully ACKed frame lasts exactly 2+108+3 = 113 ticks = 113×CLK_DIV clk cycles from busy rising to busy falling.
- **ack_err:** sticky until the next accepted FRAME write.
- **No clock stretching:** slave holding SCL is not supported; SCL is not read back.

Test Plan:
- **Full ACKed frame:** CLK_DIV=4; write FRAME=0x00341E00 with slave model always ACKing → decoded bytes 0x34, 0x1E, 0x00; START/STOP seen on the bus; busy high for exactly 452 cycles; STATUS reads 0x0; FRAME reads 0x00341E00.
- **NACK on address:** slave NACKs the first ACK slot → STOP follows immediately after bit 9; busy high for (2+36+3)×4 = 164 cycles; STATUS reads 0x2. A subsequent FRAME write clears ack_err to 0 the cycle busy rises.
- **Write while busy:** write 0x00AABBCC mid-transfer → FRAME unchanged; bus bytes unaffected; no second transfer after busy falls.
- **Reset mid-transfer:** assert reset during bit 12 for 1 cycle → next cycle scl_out=1, sda_oe=0, busy=0, STATUS=0, FRAME=0.
- **Bus protocol check:** SDA never changes while SCL=1 except the START (falling) and STOP (rising) edges; check with CLK_DIV=2 and CLK_DIV=125.
- **Unused addresses:** reads at addresses 2 and 3 return 0; writes to addresses 1, 2 and 3 have no effect on FRAME or the bus.
